// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
//   32 x 64-bit architectural register file for the pipelined LEGv8 datapath.
//   Two combinational read ports, one synchronous write port. Register 31
//   (XZR) is hardwired to zero and has no storage flops.
//
//   Optional feature (macro REG_FILE_BYPASS_EN):
//     defined   - write-through bypass: a read of the register being written
//                 this cycle returns wr_data before the edge.
//     undefined - reads always return the stored value; a same-cycle write is
//                 visible only after the rising edge.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset_n    in   asynchronous active-low reset (clears registers, wr_count)
//   wr_en      in   write enable from writeback
//   wr_addr    in   [4:0] destination register index
//   wr_data    in   [WIDTH-1:0] write data
//   rd_addr_a  in   [4:0] read port A index
//   rd_addr_b  in   [4:0] read port B index
//   rd_data_a  out  [WIDTH-1:0] read port A data (combinational)
//   rd_data_b  out  [WIDTH-1:0] read port B data (combinational)
//   wr_count   out  [7:0] saturating count of committed writes
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module reg_file_2r1w #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic [7:0]       wr_count
);

    localparam logic [4:0] ZeroAddr = 5'(ZERO_REG);

    // -----------------------------------------------------------------------
    // Write decoder: 2:4 on addr[4:3] and 3:8 on addr[2:0], ANDed with wr_en.
    // -----------------------------------------------------------------------
    logic [3:0]       dec_hi;
    logic [7:0]       dec_lo;
    logic [NREGS-1:0] wr_sel;
    logic             wr_commit;

    always_comb begin
        dec_hi = '0;
        dec_lo = '0;
        dec_hi[wr_addr[4:3]] = 1'b1;
        dec_lo[wr_addr[2:0]] = 1'b1;
        for (int i = 0; i < int'(NREGS); i++) begin
            wr_sel[i] = wr_en & dec_hi[i / 8] & dec_lo[i % 8];
        end
        // XZR has no storage, so its select line is simply never used.
        wr_sel[ZERO_REG] = 1'b0;
    end

    assign wr_commit = wr_en & (wr_addr != ZeroAddr);

    // -----------------------------------------------------------------------
    // Storage: per-register flops with a recirculating enable mux.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] regs [NREGS];

    for (genvar g = 0; g < int'(NREGS); g++) begin : g_reg
        if (g == int'(ZERO_REG)) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] reg_q;
            logic [WIDTH-1:0] reg_d;

            assign reg_d = wr_sel[g] ? wr_data : reg_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs[g] = reg_q;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux trees: 4:1 on addr[1:0], 4:1 on addr[3:2], 2:1 on addr[4].
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] lvl1_a [8];
    logic [WIDTH-1:0] lvl1_b [8];
    logic [WIDTH-1:0] lvl2_a [2];
    logic [WIDTH-1:0] lvl2_b [2];
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            lvl1_a[j] = regs[{j[2:0], rd_addr_a[1:0]}];
            lvl1_b[j] = regs[{j[2:0], rd_addr_b[1:0]}];
        end
        for (int k = 0; k < 2; k++) begin
            lvl2_a[k] = lvl1_a[{k[0], rd_addr_a[3:2]}];
            lvl2_b[k] = lvl1_b[{k[0], rd_addr_b[3:2]}];
        end
        stored_a = lvl2_a[rd_addr_a[4]];
        stored_b = lvl2_b[rd_addr_b[4]];
    end

`ifdef REG_FILE_BYPASS_EN
    // Write-through: a committed write to the addressed register wins over
    // the stored word so the consumer sees it before the edge.
    logic hit_a;
    logic hit_b;

    assign hit_a     = wr_commit & (rd_addr_a == wr_addr);
    assign hit_b     = wr_commit & (rd_addr_b == wr_addr);
    assign rd_data_a = hit_a ? wr_data : stored_a;
    assign rd_data_b = hit_b ? wr_data : stored_b;
`else
    assign rd_data_a = stored_a;
    assign rd_data_b = stored_b;
`endif

    // -----------------------------------------------------------------------
    // Saturating committed-write counter.
    // -----------------------------------------------------------------------
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (wr_commit && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wr_count = count_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// tb_reg_file_2r1w
//   Scoreboard bench for reg_file_2r1w. Stimulus drives inputs 1 ns after the
//   rising edge and pushes expected values into a queue; the monitor drains
//   the queue on every falling edge and compares against the DUT outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reg_file_2r1w;

    localparam logic [63:0] Base   = 64'h0123_4567_89AB_0000;
    localparam logic [63:0] PatA   = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] Pat5   = 64'h5555_5555_5555_5555;
    localparam logic [63:0] AllOne = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SatB   = 64'hC0DE_0000_0000_0000;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [7:0]  wr_count;

    reg_file_2r1w dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // port: 0 = rd_data_a, 1 = rd_data_b, 2 = wr_count
    typedef struct {
        string       name;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = q.pop_front();
            case (e.port)
                0:       act = rd_data_a;
                1:       act = rd_data_b;
                default: act = {56'd0, wr_count};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int port, input logic [63:0] v);
        exp_t e;
        e.name = name;
        e.port = port;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wr_pat(input int i);
        return (i == 31) ? 64'd0 : Base + 64'(i);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = AllOne;
        rd_addr_a = 5'd3;
        rd_addr_b = 5'd3;

        // Reset held with write traffic: nothing may stick.
        step();
        wr_addr = 5'd9;
        step();
        for (int i = 0; i < 32; i++) begin
            wr_addr   = 5'(i);
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            expect_val("reset_rd_a", 0, 64'd0);
            expect_val("reset_rd_b", 1, 64'd0);
            expect_val("reset_count", 2, 64'd0);
            step();
        end
        wr_en   = 1'b0;
        reset_n = 1'b1;
        step();
        rd_addr_a = 5'd3;
        rd_addr_b = 5'd9;
        expect_val("post_reset_rd_a", 0, 64'd0);
        expect_val("post_reset_rd_b", 1, 64'd0);
        expect_val("post_reset_count", 2, 64'd0);
        step();

        // Write registers 0..30.
        for (int i = 0; i < 31; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = Base + 64'(i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            expect_val("readback_a", 0, wr_pat(i));
            expect_val("readback_b", 1, wr_pat(31 - i));
            step();
        end
        expect_val("count_after_31", 2, 64'd31);
        step();

        // Writes to XZR are dropped and not counted.
        wr_en     = 1'b1;
        wr_addr   = 5'd31;
        wr_data   = AllOne;
        rd_addr_a = 5'd31;
        step();
        wr_en = 1'b0;
        expect_val("xzr_read", 0, 64'd0);
        expect_val("xzr_count", 2, 64'd31);
        step();

        // Same-cycle read/write of register 5.
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = PatA;
        step();
        wr_data   = Pat5;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd5;
`ifdef REG_FILE_BYPASS_EN
        expect_val("same_cycle_a", 0, Pat5);
        expect_val("same_cycle_b", 1, Pat5);
`else
        expect_val("same_cycle_a", 0, PatA);
        expect_val("same_cycle_b", 1, PatA);
`endif
        step();
        wr_en = 1'b0;
        expect_val("after_edge_a", 0, Pat5);
        expect_val("after_edge_b", 1, Pat5);
        expect_val("count_after_5", 2, 64'd33);
        step();

        // Reset asserted 200 ps before a write edge to register 7.
        wr_en     = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = AllOne;
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd5;
        #8.8;
        reset_n = 1'b0;
        step();
        wr_en   = 1'b0;
        reset_n = 1'b1;
        expect_val("midreset_r7", 0, 64'd0);
        expect_val("midreset_r5", 1, 64'd0);
        expect_val("midreset_count", 2, 64'd0);
        step();

        // 300 writes to register 1: counter saturates at 255.
        rd_addr_a = 5'd1;
        for (int i = 0; i < 300; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'd1;
            wr_data = SatB + 64'(i);
            step();
            if (i == 253) expect_val("count_254", 2, 64'd254);
            if (i == 254) expect_val("count_255", 2, 64'd255);
        end
        wr_en = 1'b0;
        expect_val("sat_count", 2, 64'd255);
        expect_val("sat_last_data", 0, SatB + 64'd299);
        step();
        step();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry x 64-bit architectural register file for the pipelined ARM (LEGv8) datapath.
- Provides the storage words that the 32:1 read-port multiplexer trees select from, plus the write port driven by the writeback stage.
- Two read ports and one write port. Register 31 (XZR) is hardwired to zero.
- Built from per-bit D flip-flops, a 5:32 write decoder and per-port 32:1 mux trees. Every gate has a 50 ps delay and at most 4 inputs.

Parameters:
- WIDTH, 64, data width of each register in bits.
- NREGS, 32, number of registers; fixed at 32 because addresses are 5 bits.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable from the writeback stage.
- wr_addr  input  5  destination register index.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  5  read port A register index.
- rd_addr_b  input  5  read port B register index.
- rd_data_a  output  WIDTH  read port A data (combinational from storage).
- rd_data_b  output  WIDTH  read port B data (combinational from storage).
- wr_count  output  8  saturating count of committed writes, for debug and verification.

Behaviour:
- Reset:
  - reset_n low clears all 32 registers and wr_count to 0 immediately, independent of clk.
  - rd_data_a/b therefore read 0 while reset is held.
  - Deassertion takes effect at the next rising edge after reset_n returns high.
  - Reset asserted mid-write wins: the write is discarded.
- Write:
  - On a rising clk with wr_en=1 and wr_addr != 31, register[wr_addr] <= wr_data.
  - The write decoder is 5:32, built as 2:4 and 3:8 stages ANDed with wr_en.
  - Each register bit is a DFF with enable, implemented as a 2:1 mux recirculating Q.
- Zero register:
  - Writes to register 31 are ignored; the storage for 31 is constant 0 with no flops.
  - wr_count is not incremented by writes to register 31.
- Read:
  - rd_data_x = register[rd_addr_x] via a 32:1 mux tree. Latency is 0 cycles (combinational).
  - Without the optional feature, a same-cycle write to the register being read is visible only after the edge. The read returns the old value until then.
  - Both ports may read the same address simultaneously; both return the identical value.
- wr_count:
  - Increments by 1 at each rising edge with wr_en=1 and wr_addr != 31.
  - Saturates at 255 and does not wrap.
- Unknown inputs: X on wr_en must not corrupt registers when the reset value is in effect; the bench checks this only after reset.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through bypass.
  - If wr_en=1, wr_addr != 31 and rd_addr_x == wr_addr, then rd_data_x = wr_data in the same cycle.
  - Implementation: a 5-bit equality compare per port (XNOR plus a 4-input AND tree), then a final 2:1 mux.
  - Adds roughly 4 gate delays to the read path.
- Undefined: no bypass logic. The read returns the stored value; the pipeline relies on writing in the first half-cycle or on forwarding.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with arbitrary write traffic -> all reads of addresses 0..31 return 0 and wr_count=0; release, then read -> still 0.
- Write/readback: write reg i = 64'h0123_4567_89AB_0000 + i for i=0..30, then read on A ascending and B descending -> exact values; wr_count=31.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to reg 31 -> rd_data_a with rd_addr_a=31 is 0; wr_count unchanged.
- Same-cycle read/write: reg 5 = 64'hAAAA..., then write 64'h5555... to reg 5 while reading 5:
  - Without the macro: rd_data_a = 64'hAAAA... before the edge and 64'h5555... after it.
  - With the macro: 64'h5555... immediately.
- Mid-operation reset: assert reset_n low 200 ps before a write edge to reg 7 -> reg 7 = 0 after release; no write is committed.
- Saturation: 300 consecutive writes to reg 1 -> wr_count=255; reg 1 holds the last data written.
